// File: rtl/rsa_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rsa_pkg
// Description : Shared constants for the modular exponentiation datapath:
//               default widths, top-level and multiplier state encodings,
//               and the radix-4 Montgomery quotient-digit helper.
// Revision    : 1.0 - initial release
// ============================================================================
package rsa_pkg;

    // Default operand width and the matching bit-index counter width
    localparam int c_default_bit_len      = 64;
    localparam int c_default_log2_bit_len = 6;

    // mod_exp sequencer states
    localparam logic [2:0] c_st_idle      = 3'd0;
    localparam logic [2:0] c_st_to_mont   = 3'd1;
    localparam logic [2:0] c_st_init_one  = 3'd2;
    localparam logic [2:0] c_st_square    = 3'd3;
    localparam logic [2:0] c_st_mult      = 3'd4;
    localparam logic [2:0] c_st_from_mont = 3'd5;
    localparam logic [2:0] c_st_done      = 3'd6;

    // mon_prod internal states
    localparam logic [1:0] c_mp_idle = 2'd0;
    localparam logic [1:0] c_mp_loop = 2'd1;
    localparam logic [1:0] c_mp_fix  = 2'd2;

    // Radix-4 quotient digit q = t * (-M^-1 mod 4) mod 4.
    // For odd M: M = 1 (mod 4) gives -M^-1 = 3, M = 3 (mod 4) gives -M^-1 = 1,
    // so only bit 1 of the modulus is needed.
    function automatic logic [1:0] mont_q_digit(input logic [1:0] t,
                                                input logic       m_bit1);
        logic [3:0] prod;
        prod = {2'b00, t} * (m_bit1 ? 4'd1 : 4'd3);
        return prod[1:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/mon_prod.sv
`default_nettype none
// ============================================================================
// Module      : mon_prod
// Description : Radix-4 Montgomery multiplier. Computes A*B*R^-1 mod M with
//               R = 2^bitLen, fully reduced (< M) when A < 2^bitLen, B < M.
//               Fixed latency: i_start in cycle 0, o_done in cycle
//               bitLen/2 + 2 (one load cycle, bitLen/2 digit steps, one
//               reduction cycle).
// Ports       : clk, rst      - clock, synchronous active-high reset
//               i_start       - one-cycle request, accepted when idle
//               i_a, i_b      - operands, captured on i_start
//               i_m           - odd modulus, held stable by the caller
//               o_done        - one-cycle pulse, o_result valid
//               o_result      - Montgomery product
// Revision    : 1.0 - initial release
// ============================================================================
module mon_prod
    import rsa_pkg::*;
#(
    parameter int bitLen     = c_default_bit_len,
    parameter int log2BitLen = c_default_log2_bit_len
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic [bitLen-1:0] i_a,
    input  logic [bitLen-1:0] i_b,
    input  logic [bitLen-1:0] i_m,
    output logic              o_done,
    output logic [bitLen-1:0] o_result
);

    // Partial sum stays below M + B < 2M; one step's pre-shift sum is below
    // 8M, so three guard bits are enough.
    localparam int SW = bitLen + 3;
    localparam logic [log2BitLen-1:0] c_last_step = log2BitLen'(bitLen / 2 - 1);

    logic [1:0]            r_state_q, w_state_d;
    logic [bitLen-1:0]     r_a_q,     w_a_d;
    logic [bitLen-1:0]     r_b_q,     w_b_d;
    logic [SW-1:0]         r_s_q,     w_s_d;
    logic [log2BitLen-1:0] r_cnt_q,   w_cnt_d;
    logic                  r_done_q,  w_done_d;
    logic [bitLen-1:0]     r_res_q,   w_res_d;

    logic [SW-1:0]         w_t;
    logic [1:0]            w_q;
    logic [SW-1:0]         w_tq;

    // x * d for a radix-4 digit d, extended to the sum width
    function automatic logic [SW-1:0] mul_digit(input logic [bitLen-1:0] x,
                                                input logic [1:0]        d);
        logic [SW-1:0] xe;
        xe = SW'(x);
        case (d)
            2'd0:    return '0;
            2'd1:    return xe;
            2'd2:    return xe << 1;
            default: return xe + (xe << 1);
        endcase
    endfunction

    // One digit step: S = (S + a_i*B + q*M) / 4, exact by choice of q
    always_comb begin
        w_t  = r_s_q + mul_digit(r_b_q, r_a_q[1:0]);
        w_q  = mont_q_digit(w_t[1:0], i_m[1]);
        w_tq = w_t + mul_digit(i_m, w_q);
    end

    always_comb begin
        w_state_d = r_state_q;
        w_a_d     = r_a_q;
        w_b_d     = r_b_q;
        w_s_d     = r_s_q;
        w_cnt_d   = r_cnt_q;
        w_done_d  = 1'b0;
        w_res_d   = r_res_q;
        case (r_state_q)
            c_mp_idle: begin
                if (i_start) begin
                    w_a_d     = i_a;
                    w_b_d     = i_b;
                    w_s_d     = '0;
                    w_cnt_d   = c_last_step;
                    w_state_d = c_mp_loop;
                end
            end
            c_mp_loop: begin
                w_s_d = w_tq >> 2;
                w_a_d = r_a_q >> 2;
                if (r_cnt_q == '0) begin
                    w_state_d = c_mp_fix;
                end else begin
                    w_cnt_d = r_cnt_q - log2BitLen'(1);
                end
            end
            c_mp_fix: begin
                // Final S < 2M: a single conditional subtraction reduces it
                w_res_d   = bitLen'((r_s_q >= SW'(i_m)) ? (r_s_q - SW'(i_m)) : r_s_q);
                w_done_d  = 1'b1;
                w_state_d = c_mp_idle;
            end
            default: begin
                w_state_d = c_mp_idle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= c_mp_idle;
            r_a_q     <= '0;
            r_b_q     <= '0;
            r_s_q     <= '0;
            r_cnt_q   <= '0;
            r_done_q  <= 1'b0;
            r_res_q   <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_a_q     <= w_a_d;
            r_b_q     <= w_b_d;
            r_s_q     <= w_s_d;
            r_cnt_q   <= w_cnt_d;
            r_done_q  <= w_done_d;
            r_res_q   <= w_res_d;
        end
    end

    assign o_done   = r_done_q;
    assign o_result = r_res_q;

endmodule
`default_nettype wire

// File: rtl/mod_exp.sv
`default_nettype none
// ============================================================================
// Module      : mod_exp
// Description : Montgomery-ladder-free left-to-right modular exponentiation
//               X^E mod M. Every exponent bit costs one squaring, set bits
//               add one multiply; all MonPro operations run on a single
//               mon_prod instance.
// Ports       : clk, rst  - clock, synchronous active-high reset
//               start     - one-cycle request, accepted only in IDLE
//               base      - X (< M)
//               exponent  - E, scanned MSB first
//               modulus   - M (odd, > 1)
//               r2        - R^2 mod M, R = 2^bitLen
//               busy      - operation in progress
//               done      - one-cycle pulse, result valid
//               result    - X^E mod M, held until the next completion/reset
// Revision    : 1.0 - initial release
// ============================================================================
module mod_exp
    import rsa_pkg::*;
#(
    parameter int bitLen     = c_default_bit_len,
    parameter int log2BitLen = c_default_log2_bit_len
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [bitLen-1:0] base,
    input  logic [bitLen-1:0] exponent,
    input  logic [bitLen-1:0] modulus,
    input  logic [bitLen-1:0] r2,
    output logic              busy,
    output logic              done,
    output logic [bitLen-1:0] result
);

    localparam logic [bitLen-1:0]     c_one       = {{(bitLen-1){1'b0}}, 1'b1};
    localparam logic [log2BitLen-1:0] c_top_index = log2BitLen'(bitLen - 1);

    logic [2:0]            r_state_q,    w_state_d;
    logic [log2BitLen-1:0] r_idx_q,      w_idx_d;
    logic [bitLen-1:0]     r_exp_q,      w_exp_d;
    logic [bitLen-1:0]     r_mod_q,      w_mod_d;
    logic [bitLen-1:0]     r_r2_q,       w_r2_d;
    logic [bitLen-1:0]     r_xm_q,       w_xm_d;
    logic [bitLen-1:0]     r_acc_q,      w_acc_d;
    logic [bitLen-1:0]     r_opa_q,      w_opa_d;
    logic [bitLen-1:0]     r_opb_q,      w_opb_d;
    logic                  r_mm_start_q, w_mm_start_d;
    logic [bitLen-1:0]     r_result_q,   w_result_d;

    logic                  w_mm_done;
    logic [bitLen-1:0]     w_mm_result;

    // Sequencer. Each transition out of a MonPro state happens on the
    // mm_done edge and, in the same edge, loads the next operand pair and
    // raises mm_start for the following cycle. Each MonPro therefore takes
    // L_mm + 1 cycles and the operand registers are stable throughout.
    always_comb begin
        w_state_d    = r_state_q;
        w_idx_d      = r_idx_q;
        w_exp_d      = r_exp_q;
        w_mod_d      = r_mod_q;
        w_r2_d       = r_r2_q;
        w_xm_d       = r_xm_q;
        w_acc_d      = r_acc_q;
        w_opa_d      = r_opa_q;
        w_opb_d      = r_opb_q;
        w_mm_start_d = 1'b0;
        w_result_d   = r_result_q;
        case (r_state_q)
            c_st_idle: begin
                if (start) begin
                    // base only feeds the first MonPro, so the operand
                    // register is where it is held
                    w_exp_d      = exponent;
                    w_mod_d      = modulus;
                    w_r2_d       = r2;
                    w_opa_d      = base;
                    w_opb_d      = r2;
                    w_mm_start_d = 1'b1;
                    w_state_d    = c_st_to_mont;
                end
            end
            c_st_to_mont: begin
                if (w_mm_done) begin
                    w_xm_d       = w_mm_result;
                    w_opa_d      = c_one;
                    w_opb_d      = r_r2_q;
                    w_idx_d      = c_top_index;
                    w_mm_start_d = 1'b1;
                    w_state_d    = c_st_init_one;
                end
            end
            c_st_init_one: begin
                if (w_mm_done) begin
                    w_acc_d      = w_mm_result;
                    w_opa_d      = w_mm_result;
                    w_opb_d      = w_mm_result;
                    w_mm_start_d = 1'b1;
                    w_state_d    = c_st_square;
                end
            end
            c_st_square: begin
                if (w_mm_done) begin
                    w_acc_d      = w_mm_result;
                    w_opa_d      = w_mm_result;
                    w_mm_start_d = 1'b1;
                    if (r_exp_q[r_idx_q]) begin
                        w_opb_d   = r_xm_q;
                        w_state_d = c_st_mult;
                    end else if (r_idx_q == '0) begin
                        w_opb_d   = c_one;
                        w_state_d = c_st_from_mont;
                    end else begin
                        w_opb_d   = w_mm_result;
                        w_idx_d   = r_idx_q - log2BitLen'(1);
                        w_state_d = c_st_square;
                    end
                end
            end
            c_st_mult: begin
                if (w_mm_done) begin
                    w_acc_d      = w_mm_result;
                    w_opa_d      = w_mm_result;
                    w_mm_start_d = 1'b1;
                    if (r_idx_q == '0) begin
                        w_opb_d   = c_one;
                        w_state_d = c_st_from_mont;
                    end else begin
                        w_opb_d   = w_mm_result;
                        w_idx_d   = r_idx_q - log2BitLen'(1);
                        w_state_d = c_st_square;
                    end
                end
            end
            c_st_from_mont: begin
                if (w_mm_done) begin
                    w_acc_d    = w_mm_result;
                    w_result_d = (w_mm_result >= r_mod_q) ? (w_mm_result - r_mod_q)
                                                          : w_mm_result;
                    w_state_d  = c_st_done;
                end
            end
            c_st_done: begin
                w_state_d = c_st_idle;
            end
            default: begin
                w_state_d = c_st_idle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q    <= c_st_idle;
            r_idx_q      <= '0;
            r_exp_q      <= '0;
            r_mod_q      <= '0;
            r_r2_q       <= '0;
            r_xm_q       <= '0;
            r_acc_q      <= '0;
            r_opa_q      <= '0;
            r_opb_q      <= '0;
            r_mm_start_q <= 1'b0;
            r_result_q   <= '0;
        end else begin
            r_state_q    <= w_state_d;
            r_idx_q      <= w_idx_d;
            r_exp_q      <= w_exp_d;
            r_mod_q      <= w_mod_d;
            r_r2_q       <= w_r2_d;
            r_xm_q       <= w_xm_d;
            r_acc_q      <= w_acc_d;
            r_opa_q      <= w_opa_d;
            r_opb_q      <= w_opb_d;
            r_mm_start_q <= w_mm_start_d;
            r_result_q   <= w_result_d;
        end
    end

    mon_prod #(
        .bitLen     (bitLen),
        .log2BitLen (log2BitLen)
    ) u_mon_prod (
        .clk      (clk),
        .rst      (rst),
        .i_start  (r_mm_start_q),
        .i_a      (r_opa_q),
        .i_b      (r_opb_q),
        .i_m      (r_mod_q),
        .o_done   (w_mm_done),
        .o_result (w_mm_result)
    );

    assign busy   = (r_state_q != c_st_idle) && (r_state_q != c_st_done);
    assign done   = (r_state_q == c_st_done);
    assign result = r_result_q;

endmodule
`default_nettype wire

// File: tb/tb_mod_exp.sv
`default_nettype none
// ============================================================================
// Module      : tb_mod_exp
// Description : Directed self-checking bench for mod_exp at bitLen = 8.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mod_exp;

    localparam int BL    = 8;
    localparam int LBL   = 3;
    // mon_prod latency: load cycle + BL/2 radix-4 steps + reduction cycle
    localparam int L_MM  = BL / 2 + 2;
    localparam int BOUND = 400;
    localparam int QUIET = 130;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [BL-1:0] base;
    logic [BL-1:0] exponent;
    logic [BL-1:0] modulus;
    logic [BL-1:0] r2;
    logic          busy;
    logic          done;
    logic [BL-1:0] result;

    int n_vec = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    mod_exp #(
        .bitLen     (BL),
        .log2BitLen (LBL)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .base     (base),
        .exponent (exponent),
        .modulus  (modulus),
        .r2       (r2),
        .busy     (busy),
        .done     (done),
        .result   (result)
    );

    function automatic int lat_for(input int pop);
        return (3 + BL + pop) * (L_MM + 1) + 1;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_mis++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Counts done pulses over a quiet window
    task automatic count_done(output int pulses);
        pulses = 0;
        repeat (QUIET) begin
            @(posedge clk); #1;
            if (done) pulses++;
        end
    endtask

    task automatic run_op(input string tag, input logic [BL-1:0] b, input logic [BL-1:0] e,
                          input logic [BL-1:0] m, input logic [BL-1:0] rr,
                          input logic [BL-1:0] expr, input int pop, input bit perturb);
        int cyc;
        int extra;
        bit busy_ok;
        bit seen;
        @(posedge clk); #1;
        base = b; exponent = e; modulus = m; r2 = rr; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1; busy_ok = 1'b1; seen = 1'b0;
        chk({tag, "_busy_rise"}, 64'(busy), 64'd1);
        while (cyc < BOUND && !seen) begin
            if (done) begin
                seen = 1'b1;
            end else begin
                if (!busy) busy_ok = 1'b0;
                if (perturb) begin
                    base     = ~base;
                    exponent = exponent ^ 8'h5A;
                    start    = (cyc == 10) || (cyc == 40);
                end
                @(posedge clk); #1;
                cyc++;
            end
        end
        chk({tag, "_done_seen"}, 64'(seen), 64'd1);
        chk({tag, "_latency"}, 64'(cyc), 64'(lat_for(pop)));
        chk({tag, "_busy_held"}, 64'(busy_ok), 64'd1);
        chk({tag, "_busy_in_done"}, 64'(busy), 64'd0);
        chk({tag, "_result"}, 64'(result), 64'(expr));
        if (perturb) start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk({tag, "_done_width"}, 64'(done), 64'd0);
        chk({tag, "_idle_busy"}, 64'(busy), 64'd0);
        count_done(extra);
        chk({tag, "_single_done"}, 64'(extra), 64'd0);
        chk({tag, "_result_held"}, 64'(result), 64'(expr));
    endtask

    initial begin
        int cyc;
        int extra;
        rst = 1'b1; start = 1'b1;
        base = 8'd7; exponent = 8'd13; modulus = 8'd187; r2 = 8'd86;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0; start = 1'b0;
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_result", 64'(result), 64'd0);
        @(posedge clk); #1;
        chk("reset_start_ignored", 64'(busy), 64'd0);

        run_op("x7_e13",    8'd7,   8'd13,  8'd187, 8'd86, 8'd57, 3, 1'b0);
        run_op("x5_e0",     8'd5,   8'd0,   8'd187, 8'd86, 8'd1,  0, 1'b0);
        run_op("x5_e1",     8'd5,   8'd1,   8'd187, 8'd86, 8'd5,  1, 1'b0);
        run_op("fermat",    8'd3,   8'd250, 8'd251, 8'd25, 8'd1,  6, 1'b0);
        run_op("perturbed", 8'd186, 8'd2,   8'd187, 8'd86, 8'd1,  1, 1'b1);

        // Abort mid-SQUARE (first squaring spans cycles 15..21 after start)
        @(posedge clk); #1;
        base = 8'd7; exponent = 8'd13; modulus = 8'd187; r2 = 8'd86; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        while (cyc < 17) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("abort_busy_before", 64'(busy), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_result", 64'(result), 64'd0);
        count_done(extra);
        chk("abort_no_done", 64'(extra), 64'd0);

        run_op("after_abort", 8'd7, 8'd13, 8'd187, 8'd86, 8'd57, 3, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mod_exp.md
MOD_EXP -- requirements
Module: mod_exp

Interface
REQ-001 Parameter bitLen, default 64: operand, exponent and result width in bits.
REQ-002 Parameter log2BitLen, default 6: width of the exponent bit index counter; SHALL equal ceil(log2(bitLen)).
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 start  input  1  single-cycle request; sampled only in IDLE.
REQ-006 base  input  bitLen  message/base X; precondition X < M.
REQ-007 exponent  input  bitLen  exponent E, scanned MSB first.
REQ-008 modulus  input  bitLen  modulus M; precondition M odd, M > 1.
REQ-009 r2  input  bitLen  precomputed R^2 mod M, where R = 2^bitLen.
REQ-010 busy  output  1  high from the cycle after an accepted start until done asserts.
REQ-011 done  output  1  one-cycle pulse when result is valid.
REQ-012 result  output  bitLen  X^E mod M, fully reduced; held until the next accepted start or reset.

Function
REQ-013 On start in IDLE, the block SHALL register base, exponent, modulus and r2; later input changes SHALL have no effect until done.
REQ-014 start while busy SHALL be ignored, with no effect on state or registers.
REQ-015 State machine: IDLE -> TO_MONT -> INIT_ONE -> SQUARE -> (MULT if current E bit = 1) -> SQUARE ... -> FROM_MONT -> DONE -> IDLE.
REQ-016 TO_MONT SHALL compute Xm = MonPro(X, r2); INIT_ONE SHALL compute Acc = MonPro(1, r2) = R mod M.
REQ-017 For bit index i = bitLen-1 down to 0, SQUARE SHALL compute Acc = MonPro(Acc, Acc); then, if E[i] = 1, MULT SHALL compute Acc = MonPro(Acc, Xm).
REQ-018 All bitLen exponent bits SHALL be processed, with no leading-zero skip, giving data-independent squaring count.
REQ-019 FROM_MONT SHALL compute Acc = MonPro(Acc, 1); if Acc >= M, M SHALL be subtracted once before loading result.
REQ-020 Each MonPro state SHALL issue a one-cycle mm_start to the multiplier, hold its operands stable, and wait for mm_done; the next operation SHALL be issued no earlier than the cycle after mm_done.
REQ-021 Latency from accepted start to done SHALL be exactly N_ops*(L_mm+1)+1 cycles, where N_ops = 3 + bitLen + popcount(E) and L_mm is the multiplier latency from mm_start to mm_done.
REQ-022 Bit index counter SHALL decrement after each SQUARE/MULT pair and SHALL leave the loop after index 0, without wrap-around.
REQ-023 E = 0 SHALL yield result = 1; E = 1 SHALL yield result = X.
REQ-024 In DONE, done SHALL be 1 for exactly one cycle, busy SHALL be 0, and the state SHALL return to IDLE; a start in that same cycle SHALL be ignored.

Reset
REQ-025 When rst = 1 at a rising clk edge, the block SHALL enter IDLE with busy = 0, done = 0, result = 0, and bit counter = 0; rst SHALL take priority over start.
REQ-026 Reset during any operation SHALL abort it; the multiplier SHALL also be reset, and no done pulse SHALL follow.

Structure
REQ-027 State encodings, bitLen default and log2BitLen default SHALL live in the shared package rsa_pkg.
REQ-028 The block SHALL instantiate exactly one Montgomery multiplier sub-module, mon_prod (radix-4, bitLen parameterised), using a start/stop handshake; no other sub-modules.
REQ-029 Operand muxing for MonPro inputs (X, r2, Acc, Xm, constant 1) SHALL be a single registered selection driven by state.

Verification (bench bitLen = 8, R = 256)
REQ-030 M=187, r2=86, X=7, E=13 -> result=57, exactly one done pulse, latency per REQ-021 with popcount 3.
REQ-031 M=187, r2=86, X=5, E=0 -> result=1; and with X=5, E=1 -> result=5.
REQ-032 M=251, r2=25, X=3, E=250 -> result=1 (Fermat check).
REQ-033 M=187, r2=86, X=186, E=2 -> result=1; toggling base/exponent while busy leaves the result unchanged.
REQ-034 rst asserted mid-SQUARE for one cycle -> busy=0, done=0, result=0 next cycle, no later done; a fresh start then gives the correct result.
REQ-035 start pulsed while busy and in the DONE cycle -> ignored; a single done pulse and an unchanged result.
